// File: rtl/draw_sequencer.sv
// ---------------------------------------------------------------------------
// draw_sequencer
//
// Command-driven pixel scheduler sitting between the Mastermind game FSM and
// the 160x120 VGA adapter. One shape command is accepted at a time, its pixel
// raster is walked row-major at one pixel per cycle, and every pixel is
// presented on registered x/y/colour/plot outputs. A one-cycle done pulse
// follows the last pixel.
//
// Ports
//   clock       in   1  system clock
//   resetn      in   1  synchronous, active-low reset
//   cmd_valid   in   1  command present
//   cmd_ready   out  1  sequencer idle and able to accept a command
//   cmd_shape   in   3  0 big 20x20, 1 medium 10x10, 2 peg row 22x4,
//                       3 erase 110x20, 4 clear 160x120, 5-7 no pixels
//   cmd_x       in   8  shape origin column
//   cmd_y       in   7  shape origin row
//   cmd_colour  in   3  fill colour for shapes 0-2
//   cmd_pegs    in   3  pegs drawn in a peg row (values above 4 clamp to 4)
//   vga_x       out  8  pixel column
//   vga_y       out  7  pixel row
//   vga_colour  out  3  pixel colour
//   vga_plot    out  1  write strobe for the presented pixel
//   busy        out  1  high while drawing and during the done cycle
//   done        out  1  one-cycle completion pulse
// ---------------------------------------------------------------------------
module draw_sequencer #(
  parameter int         SCREEN_W     = 160,
  parameter int         SCREEN_H     = 120,
  parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_shape,
  input  logic [7:0] cmd_x,
  input  logic [6:0] cmd_y,
  input  logic [2:0] cmd_colour,
  input  logic [2:0] cmd_pegs,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DRAW = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [8:0] SCREEN_W_L = 9'(SCREEN_W);
  localparam logic [7:0] SCREEN_H_L = 8'(SCREEN_H);

  // Last column index (width - 1) of each shape.
  function automatic logic [7:0] shape_w_last(input logic [2:0] shape);
    logic [7:0] w;
    case (shape)
      3'd0:    w = 8'd19;
      3'd1:    w = 8'd9;
      3'd2:    w = 8'd21;
      3'd3:    w = 8'd109;
      3'd4:    w = 8'd159;
      default: w = 8'd0;
    endcase
    return w;
  endfunction

  // Last row index (height - 1) of each shape.
  function automatic logic [6:0] shape_h_last(input logic [2:0] shape);
    logic [6:0] h;
    case (shape)
      3'd0:    h = 7'd19;
      3'd1:    h = 7'd9;
      3'd2:    h = 7'd3;
      3'd3:    h = 7'd19;
      3'd4:    h = 7'd119;
      default: h = 7'd0;
    endcase
    return h;
  endfunction

  // Peg-row column mask: pegs start at columns 0, 6, 12 and 18; columns
  // 4,5,10,11,16,17,20,21 are gaps, so the last peg only keeps columns 18-19.
  function automatic logic peg_col_on(input logic [7:0] lx, input logic [2:0] pegs);
    logic [2:0] peg;
    logic       hit;
    if (lx < 8'd4) begin
      hit = 1'b1;
      peg = 3'd0;
    end else if ((lx >= 8'd6) && (lx < 8'd10)) begin
      hit = 1'b1;
      peg = 3'd1;
    end else if ((lx >= 8'd12) && (lx < 8'd16)) begin
      hit = 1'b1;
      peg = 3'd2;
    end else if ((lx >= 8'd18) && (lx < 8'd20)) begin
      hit = 1'b1;
      peg = 3'd3;
    end else begin
      hit = 1'b0;
      peg = 3'd0;
    end
    return hit && (peg < pegs);
  endfunction

  logic [1:0] state_q,      state_d;
  logic [2:0] shape_q,      shape_d;
  logic [7:0] org_x_q,      org_x_d;
  logic [6:0] org_y_q,      org_y_d;
  logic [2:0] colour_q,     colour_d;
  logic [2:0] pegs_q,       pegs_d;
  logic [7:0] w_last_q,     w_last_d;
  logic [6:0] h_last_q,     h_last_d;
  logic [7:0] col_q,        col_d;
  logic [6:0] row_q,        row_d;
  logic [7:0] vga_x_q,      vga_x_d;
  logic [6:0] vga_y_q,      vga_y_d;
  logic [2:0] vga_colour_q, vga_colour_d;
  logic       vga_plot_q,   vga_plot_d;
  logic       ready_q,      ready_d;
  logic       busy_q,       busy_d;
  logic       done_q,       done_d;

  // Incoming command after shape-specific overrides.
  logic [7:0] in_x_s;
  logic [6:0] in_y_s;
  logic [2:0] in_colour_s;
  logic [2:0] in_pegs_s;

  // Source of the pixel being loaded into the output registers.
  logic       present_s;
  logic [2:0] pix_shape_s;
  logic [7:0] pix_x_s;
  logic [6:0] pix_y_s;
  logic [2:0] pix_colour_s;
  logic [2:0] pix_pegs_s;
  logic [8:0] sum_x_s;
  logic [7:0] sum_y_s;
  logic       on_screen_s;
  logic       peg_ok_s;

  // Resolve the command fields as they will be latched at acceptance.
  always_comb begin
    if (cmd_shape == 3'd4) begin
      in_x_s = 8'd0;
      in_y_s = 7'd0;
    end else begin
      in_x_s = cmd_x;
      in_y_s = cmd_y;
    end
    if ((cmd_shape == 3'd3) || (cmd_shape == 3'd4)) begin
      in_colour_s = CLEAR_COLOUR;
    end else begin
      in_colour_s = cmd_colour;
    end
    if (cmd_pegs > 3'd4) begin
      in_pegs_s = 3'd4;
    end else begin
      in_pegs_s = cmd_pegs;
    end
  end

  // Sequencer next-state, raster counters and next output pixel.
  always_comb begin
    state_d      = state_q;
    shape_d      = shape_q;
    org_x_d      = org_x_q;
    org_y_d      = org_y_q;
    colour_d     = colour_q;
    pegs_d       = pegs_q;
    w_last_d     = w_last_q;
    h_last_d     = h_last_q;
    col_d        = col_q;
    row_d        = row_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    present_s    = 1'b0;
    pix_shape_s  = shape_q;
    pix_x_s      = org_x_q;
    pix_y_s      = org_y_q;
    pix_colour_s = colour_q;
    pix_pegs_s   = pegs_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          shape_d  = cmd_shape;
          org_x_d  = in_x_s;
          org_y_d  = in_y_s;
          colour_d = in_colour_s;
          pegs_d   = in_pegs_s;
          w_last_d = shape_w_last(cmd_shape);
          h_last_d = shape_h_last(cmd_shape);
          col_d    = 8'd0;
          row_d    = 7'd0;
          if (cmd_shape <= 3'd4) begin
            // Pixel 0 is loaded on the acceptance edge itself.
            state_d      = S_DRAW;
            present_s    = 1'b1;
            pix_shape_s  = cmd_shape;
            pix_x_s      = in_x_s;
            pix_y_s      = in_y_s;
            pix_colour_s = in_colour_s;
            pix_pegs_s   = in_pegs_s;
          end else begin
            // Shapes with no pixels go straight to the done cycle.
            state_d = S_DONE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRAW: begin
        if ((col_q == w_last_q) && (row_q == h_last_q)) begin
          state_d = S_DONE;
        end else begin
          present_s = 1'b1;
          if (col_q == w_last_q) begin
            col_d = 8'd0;
            row_d = row_q + 7'd1;
          end else begin
            col_d = col_q + 8'd1;
            row_d = row_q;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Addresses are summed one bit wider so off-screen pixels are detected
    // instead of wrapping back onto the screen.
    sum_x_s     = {1'b0, pix_x_s} + {1'b0, col_d};
    sum_y_s     = {1'b0, pix_y_s} + {1'b0, row_d};
    on_screen_s = (sum_x_s < SCREEN_W_L) && (sum_y_s < SCREEN_H_L);
    if (pix_shape_s == 3'd2) begin
      peg_ok_s = peg_col_on(col_d, pix_pegs_s);
    end else begin
      peg_ok_s = 1'b1;
    end

    if (present_s) begin
      vga_x_d      = sum_x_s[7:0];
      vga_y_d      = sum_y_s[6:0];
      vga_colour_d = pix_colour_s;
      vga_plot_d   = on_screen_s && peg_ok_s;
    end else begin
      vga_plot_d   = 1'b0;
    end

    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
  end

  // State, latched command and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      shape_q      <= 3'd0;
      org_x_q      <= 8'd0;
      org_y_q      <= 7'd0;
      colour_q     <= 3'd0;
      pegs_q       <= 3'd0;
      w_last_q     <= 8'd0;
      h_last_q     <= 7'd0;
      col_q        <= 8'd0;
      row_q        <= 7'd0;
      vga_x_q      <= 8'd0;
      vga_y_q      <= 7'd0;
      vga_colour_q <= 3'd0;
      vga_plot_q   <= 1'b0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shape_q      <= shape_d;
      org_x_q      <= org_x_d;
      org_y_q      <= org_y_d;
      colour_q     <= colour_d;
      pegs_q       <= pegs_d;
      w_last_q     <= w_last_d;
      h_last_q     <= h_last_d;
      col_q        <= col_d;
      row_q        <= row_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign cmd_ready  = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;

endmodule
